// File: rtl/rf_param.sv
// Parametrised register file: two combinational read ports, two write ports
// (A over B), optional write-to-read bypass and hardwired-zero register 0.
module rf_param #(
  parameter int  WIDTH    = 16,
  parameter int  NREGS    = 8,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_REG = 1'b0,
  localparam int SELW     = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  read1regsel,
  input  logic [SELW-1:0]  read2regsel,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  input  logic             wa_en,
  input  logic [SELW-1:0]  wa_sel,
  input  logic [WIDTH-1:0] wa_data,
  input  logic             wb_en,
  input  logic [SELW-1:0]  wb_sel,
  input  logic [WIDTH-1:0] wb_data,
  output logic             err,
  output logic             err_sticky
);

  localparam logic [31:0] NR = 32'(NREGS);

  logic [WIDTH-1:0] mem [NREGS];
  logic             conflict;
  logic             wa_hit;
  logic             wb_hit;
  logic             err_ev;
  logic [SELW-1:0]  rsel  [2];
  logic [WIDTH-1:0] rdata [2];

  function automatic logic in_range(input logic [SELW-1:0] s);
    return 32'(s) < NR;
  endfunction

  // wa_hit/wb_hit mean the write actually lands in storage this edge
  always_comb begin
    conflict = wa_en && wb_en && (wa_sel == wb_sel);
    wa_hit   = wa_en && in_range(wa_sel) && !(ZERO_REG && (wa_sel == '0));
    wb_hit   = wb_en && in_range(wb_sel) && !(ZERO_REG && (wb_sel == '0)) && !conflict;
    err_ev   = conflict
            || (wa_en && !in_range(wa_sel))
            || (wb_en && !in_range(wb_sel))
            || !in_range(read1regsel)
            || !in_range(read2regsel);
  end

  assign rsel[0] = read1regsel;
  assign rsel[1] = read2regsel;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      if (in_range(rsel[p]) && !(ZERO_REG && (rsel[p] == '0))) begin
        if (BYPASS && wa_hit && (wa_sel == rsel[p]))
          rdata[p] = wa_data;
        else if (BYPASS && wb_hit && (wb_sel == rsel[p]))
          rdata[p] = wb_data;
        else
          rdata[p] = mem[rsel[p]];
      end
    end
  end

  assign read1data = rdata[0];
  assign read2data = rdata[1];

  // Storage and error flags: one register stage behind the inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (wb_hit) mem[wb_sel] <= wb_data;
      if (wa_hit) mem[wa_sel] <= wa_data;
      err        <= err_ev;
      err_sticky <= err_sticky | err_ev;
    end
  end

endmodule
